fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter: PC_RESET, 32'h00000000, PC value loaded on reset.
REQ-002 SHALL have port: CLK  in  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port: nRST  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: ihit  in  1  instruction cache returned iload for iaddr this cycle.
REQ-005 SHALL have port: iload  in  32  instruction word from cache, valid when ihit.
REQ-006 SHALL have port: dhit  in  1  data cache completed request this cycle.
REQ-007 SHALL have port: dstall  in  1  memory stage has outstanding data request.
REQ-008 SHALL have port: stall  in  1  hazard unit load-use stall; hold PC and IF/ID.
REQ-009 SHALL have port: flush  in  1  taken branch/jump resolved downstream; redirect and squash.
REQ-010 SHALL have port: redirect_pc  in  32  target PC, valid with flush.
REQ-011 SHALL have port: halt  in  1  halt instruction committed downstream.
REQ-012 SHALL have port: iREN  out  1  instruction read enable.
REQ-013 SHALL have port: iaddr  out  32  current PC to instruction cache.
REQ-014 SHALL have port: instr_r  out  32  IF/ID instruction to decode.
REQ-015 SHALL have port: npc_r  out  32  IF/ID PC+4 of instr_r.
REQ-016 SHALL have port: branch_r  out  1  IF/ID flag, instr_r opcode is BEQ (6'h04) or BNE (6'h05).

Function
REQ-017 SHALL define advance = ihit & (~dstall | dhit), the same enable used by the decode register.
REQ-018 SHALL implement FSM states RUN, REDIRECT, HALTED; iaddr = PC in all states.
REQ-019 SHALL drive iREN = 1 in RUN and REDIRECT, 0 in HALTED.
REQ-020 SHALL hold PC and all IF/ID outputs unchanged on any cycle where advance = 0, except REQ-023/REQ-026.
REQ-021 RUN, advance, no flush, no stall: PC <= PC+4 (mod 2^32, wraps 32'hFFFFFFFC -> 0); instr_r <= iload; npc_r <= PC+4; branch_r <= (iload[31:26] in {04,05}).
REQ-022 RUN, advance, stall, no flush: PC and IF/ID hold.
REQ-023 flush while advance = 0: capture redirect_pc into pending target, go REDIRECT; later flush before advance overwrites target.
REQ-024 advance with flush (any state) or in REDIRECT: PC <= redirect_pc if flush else pending target; IF/ID <= bubble (instr_r 0, npc_r 0, branch_r 0); go RUN.
REQ-025 Priority: halt > flush/REDIRECT > stall > normal fetch.
REQ-026 halt asserted (any state, regardless of advance): next edge go HALTED, IF/ID <= bubble, PC holds.
REQ-027 HALTED SHALL be left only by reset; all inputs ignored.
REQ-028 Latency: instruction at PC appears on instr_r one edge after the advance cycle fetching it.

Reset
REQ-029 On nRST low, immediately: PC = PC_RESET, state RUN, instr_r = 0, npc_r = 0, branch_r = 0, pending target = 0.
REQ-030 Reset mid-REDIRECT or mid-HALTED SHALL discard pending target and return to RUN at PC_RESET.
REQ-031 After nRST release, first fetch SHALL request iaddr = PC_RESET with iREN = 1.

Verification
REQ-032 Reset release, ihit=1 each cycle, iload = 32'h8C010004 then 32'h10220003 -> iaddr 0,4,8; instr_r follows one cycle later; npc_r 4 then 8; branch_r 0 then 1.
REQ-033 ihit=1, dstall=1, dhit=0 for 3 cycles at PC=8 -> PC and IF/ID frozen; dhit=1 next cycle -> PC=12.
REQ-034 stall=1 one cycle at PC=16 -> PC stays 16, instr_r unchanged; stall=0 -> PC=20.
REQ-035 flush=1, redirect_pc=32'h40, ihit=0; then flush=1, redirect_pc=32'h80, ihit=0; then ihit=1 -> PC=32'h80, instr_r=0, state RUN.
REQ-036 halt=1 at PC=32'h24 with stall=1 and flush=1 -> HALTED, iREN=0, instr_r=0, PC=32'h24 held 10 cycles; nRST pulse -> PC=PC_RESET, iREN=1.
REQ-037 PC=32'hFFFFFFFC, advance -> PC=0, npc_r=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, talks to the instruction cache and
// produces the IF/ID pipeline register (instruction, PC+4, branch flag).
module fetch_stage #(
   parameter logic [31:0] PC_RESET = 32'h00000000
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic [31:0] iload,
   input  logic        dhit,
   input  logic        dstall,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        iREN,
   output logic [31:0] iaddr,
   output logic [31:0] instr_r,
   output logic [31:0] npc_r,
   output logic        branch_r
);

   typedef enum logic [1:0] {RUN, REDIRECT, HALTED} state_t;

   state_t      r_state;
   state_t      w_stateNext;
   logic [31:0] r_pc;
   logic [31:0] r_target;
   logic [31:0] w_pcNext;
   logic [31:0] w_targetNext;
   logic [31:0] w_instrNext;
   logic [31:0] w_npcNext;
   logic        w_branchNext;
   logic        w_advance;
   logic [31:0] w_pcPlus4;
   logic        w_isBranch;

   // The decode register shares this enable, so both stages move in lockstep.
   assign w_advance  = ihit & (~dstall | dhit);
   assign w_pcPlus4  = r_pc + 32'd4;
   assign w_isBranch = (iload[31:26] == 6'h04) || (iload[31:26] == 6'h05);

   assign iaddr = r_pc;
   assign iREN  = (r_state != HALTED);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state  <= RUN;
         r_pc     <= PC_RESET;
         r_target <= 32'h0;
         instr_r  <= 32'h0;
         npc_r    <= 32'h0;
         branch_r <= 1'b0;
      end else begin
         r_state  <= w_stateNext;
         r_pc     <= w_pcNext;
         r_target <= w_targetNext;
         instr_r  <= w_instrNext;
         npc_r    <= w_npcNext;
         branch_r <= w_branchNext;
      end
   end

   // Priority: halt, then flush / pending redirect, then stall, then fetch.
   // A flush arriving while the cache misses is parked in r_target.
   always_comb begin
      w_stateNext  = r_state;
      w_pcNext     = r_pc;
      w_targetNext = r_target;
      w_instrNext  = instr_r;
      w_npcNext    = npc_r;
      w_branchNext = branch_r;
      case (r_state)
         HALTED: begin
         end
         default: begin
            if (halt) begin
               w_stateNext  = HALTED;
               w_instrNext  = 32'h0;
               w_npcNext    = 32'h0;
               w_branchNext = 1'b0;
            end else if (flush) begin
               if (w_advance) begin
                  w_stateNext  = RUN;
                  w_pcNext     = redirect_pc;
                  w_instrNext  = 32'h0;
                  w_npcNext    = 32'h0;
                  w_branchNext = 1'b0;
               end else begin
                  w_stateNext  = REDIRECT;
                  w_targetNext = redirect_pc;
               end
            end else if (r_state == REDIRECT) begin
               if (w_advance) begin
                  w_stateNext  = RUN;
                  w_pcNext     = r_target;
                  w_instrNext  = 32'h0;
                  w_npcNext    = 32'h0;
                  w_branchNext = 1'b0;
               end
            end else if (w_advance && !stall) begin
               w_pcNext     = w_pcPlus4;
               w_instrNext  = iload;
               w_npcNext    = w_pcPlus4;
               w_branchNext = w_isBranch;
            end
         end
      endcase
   end

endmodule
